// File: rtl/laser_point_feeder_if.sv
// laser_point_feeder_if: host point-load/result signals and laser core stream signals.
interface laser_point_feeder_if;
    logic       wr_en;
    logic [5:0] wr_addr;
    logic [3:0] wr_x, wr_y;
    logic       start, busy, core_rst;
    logic [3:0] x, y;
    logic [3:0] c1x, c1y, c2x, c2y;
    logic       done, res_valid, res_timeout;
    logic [3:0] res_c1x, res_c1y, res_c2x, res_c2y;
    logic [5:0] res_cover;
    modport master (
        input  wr_en, wr_addr, wr_x, wr_y, start, c1x, c1y, c2x, c2y, done,
        output busy, core_rst, x, y, res_valid, res_timeout,
               res_c1x, res_c1y, res_c2x, res_c2y, res_cover
    );
    modport slave (
        output wr_en, wr_addr, wr_x, wr_y, start, c1x, c1y, c2x, c2y, done,
        input  busy, core_rst, x, y, res_valid, res_timeout,
               res_c1x, res_c1y, res_c2x, res_c2y, res_cover
    );
endinterface

// File: rtl/laser_point_feeder.sv
// laser_point_feeder: streams stored points into the two-circle laser core,
// captures its circle pair and scores how many stored points those circles cover.
module laser_point_feeder #(
    parameter int NPTS      = 40,
    parameter int TIMEOUT   = 1023,
    parameter int RADIUS_SQ = 16
) (
    input logic                  clk,
    input logic                  rst_n,
    laser_point_feeder_if.master bus
);
    localparam int TW = $clog2(TIMEOUT + 1);
    typedef enum logic [2:0] {IDLE, STREAM, WAIT_DONE, SCORE, REPORT} state_t;
    state_t        state;
    logic [3:0]    mem_x [NPTS];
    logic [3:0]    mem_y [NPTS];
    logic [5:0]    idx;
    logic [TW-1:0] tcnt;
    logic          covered;
    function automatic logic hit(input logic [3:0] ax, ay, cx, cy);
        logic signed [9:0] dx, dy;
        dx = $signed({6'd0, ax}) - $signed({6'd0, cx});
        dy = $signed({6'd0, ay}) - $signed({6'd0, cy});
        return (dx * dx + dy * dy) <= 10'(RADIUS_SQ);
    endfunction
    always_comb covered = hit(mem_x[idx], mem_y[idx], bus.res_c1x, bus.res_c1y) |
                          hit(mem_x[idx], mem_y[idx], bus.res_c2x, bus.res_c2y);
    // Memory survives reset; a write alongside START lands before the first read.
    always_ff @(posedge clk) begin
        if (bus.wr_en && state == IDLE && int'(bus.wr_addr) < NPTS) begin
            mem_x[bus.wr_addr] <= bus.wr_x;
            mem_y[bus.wr_addr] <= bus.wr_y;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            bus.busy        <= 1'b0;
            bus.core_rst    <= 1'b1;
            bus.x           <= '0;
            bus.y           <= '0;
            idx             <= '0;
            tcnt            <= '0;
            bus.res_valid   <= 1'b0;
            bus.res_timeout <= 1'b0;
            bus.res_c1x     <= '0;
            bus.res_c1y     <= '0;
            bus.res_c2x     <= '0;
            bus.res_c2y     <= '0;
            bus.res_cover   <= '0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    state           <= STREAM;
                    bus.busy        <= 1'b1;
                    idx             <= '0;
                    tcnt            <= '0;
                    bus.res_timeout <= 1'b0;
                    bus.res_c1x     <= '0;
                    bus.res_c1y     <= '0;
                    bus.res_c2x     <= '0;
                    bus.res_c2y     <= '0;
                    bus.res_cover   <= '0;
                end
                STREAM: begin
                    bus.core_rst <= 1'b0;
                    bus.x        <= mem_x[idx];
                    bus.y        <= mem_y[idx];
                    idx          <= idx == 6'(NPTS - 1) ? '0 : idx + 1'b1;
                    state        <= idx == 6'(NPTS - 1) ? WAIT_DONE : STREAM;
                end
                WAIT_DONE: begin
                    bus.x <= '0;
                    bus.y <= '0;
                    if (bus.done) begin
                        bus.res_c1x  <= bus.c1x;
                        bus.res_c1y  <= bus.c1y;
                        bus.res_c2x  <= bus.c2x;
                        bus.res_c2y  <= bus.c2y;
                        bus.core_rst <= 1'b1;
                        state        <= SCORE;
                    end else if (tcnt == TW'(TIMEOUT - 1)) begin
                        bus.res_timeout <= 1'b1;
                        bus.res_valid   <= 1'b1;
                        bus.core_rst    <= 1'b1;
                        state           <= REPORT;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                SCORE: begin
                    bus.res_cover <= bus.res_cover + {5'd0, covered};
                    idx           <= idx + 1'b1;
                    bus.res_valid <= idx == 6'(NPTS - 1);
                    state         <= idx == 6'(NPTS - 1) ? REPORT : SCORE;
                end
                REPORT: begin
                    bus.res_valid <= 1'b0;
                    bus.busy      <= 1'b0;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_laser_point_feeder.sv
// tb_laser_point_feeder: random and directed jobs against a point-coverage reference model.
module tb_laser_point_feeder;
    localparam int NPTS = 40, TIMEOUT = 1023, RSQ = 16;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int n_cmp = 0, n_err = 0;
    logic [3:0] mx [NPTS];
    logic [3:0] my [NPTS];
    laser_point_feeder_if bus ();
    laser_point_feeder dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask
    function automatic int model_cover(input int a1, b1, a2, b2);
        int n = 0;
        for (int i = 0; i < NPTS; i++) begin
            int px, py;
            px = int'(mx[i]);
            py = int'(my[i]);
            if ((px - a1) * (px - a1) + (py - b1) * (py - b1) <= RSQ ||
                (px - a2) * (px - a2) + (py - b2) * (py - b2) <= RSQ) n++;
        end
        return n;
    endfunction
    task automatic wr(input int a, input logic [3:0] px, py);
        bus.wr_en = 1'b1;
        bus.wr_addr = 6'(a);
        bus.wr_x = px;
        bus.wr_y = py;
        @(posedge clk); #1;
        bus.wr_en = 1'b0;
        if (a < NPTS) begin
            mx[a] = px;
            my[a] = py;
        end
    endtask
    task automatic noise_core();
        bus.c1x = 4'($urandom);
        bus.c1y = 4'($urandom);
        bus.c2x = 4'($urandom);
        bus.c2y = 4'($urandom);
    endtask
    // w = number of WAIT_DONE cycles up to and including the DONE sample; 0 = core never answers
    task automatic run_job(input int w, input logic [3:0] a1, b1, a2, b2, input bit disturb,
                           input bit ws_en, input int ws_addr, input logic [3:0] ws_x, ws_y);
        int cyc, exp_cov;
        noise_core();
        bus.start = 1'b1;
        if (ws_en) begin
            bus.wr_en = 1'b1;
            bus.wr_addr = 6'(ws_addr);
            bus.wr_x = ws_x;
            bus.wr_y = ws_y;
            mx[ws_addr] = ws_x;
            my[ws_addr] = ws_y;
        end
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.wr_en = 1'b0;
        check("accept", int'({bus.busy, bus.core_rst, bus.res_valid, bus.x, bus.y}), int'({3'b110, 8'd0}));
        check("clear", int'({bus.res_cover, bus.res_timeout, bus.res_c1x, bus.res_c2y}), 0);
        for (int k = 0; k < NPTS; k++) begin
            if (disturb && k == 5) begin
                bus.wr_en = 1'b1;
                bus.wr_addr = 6'd3;
                bus.wr_x = ~mx[3];
                bus.wr_y = ~my[3];
                bus.start = 1'b1;
                bus.done = 1'b1;
            end
            @(posedge clk); #1;
            bus.wr_en = 1'b0;
            bus.start = 1'b0;
            bus.done = 1'b0;
            check("stream", int'({bus.core_rst, bus.x, bus.y}), int'({1'b0, mx[k], my[k]}));
        end
        cyc = NPTS;
        if (w > 0) begin
            for (int i = 1; i < w; i++) begin
                bus.start = disturb;
                @(posedge clk); #1;
                cyc++;
            end
            bus.start = 1'b0;
            bus.done = 1'b1;
            bus.c1x = a1;
            bus.c1y = b1;
            bus.c2x = a2;
            bus.c2y = b2;
        end
        @(posedge clk); #1;
        cyc++;
        bus.done = 1'b0;
        noise_core();
        check("wait_xy", int'({bus.x, bus.y, bus.core_rst}), w > 0 ? 1 : 0);
        while (!bus.res_valid && cyc < 1200) begin
            @(posedge clk); #1;
            cyc++;
        end
        exp_cov = w > 0 ? model_cover(int'(a1), int'(b1), int'(a2), int'(b2)) : 0;
        check("latency", cyc, w > 0 ? 2 * NPTS + w : NPTS + TIMEOUT);
        check("res_c1", int'({bus.res_c1x, bus.res_c1y}), w > 0 ? int'({a1, b1}) : 0);
        check("res_c2", int'({bus.res_c2x, bus.res_c2y}), w > 0 ? int'({a2, b2}) : 0);
        check("res_cover", int'(bus.res_cover), exp_cov);
        check("res_timeout", int'(bus.res_timeout), w > 0 ? 0 : 1);
        check("report", int'({bus.busy, bus.core_rst}), 3);
        bus.start = disturb;
        @(posedge clk); #1;
        bus.start = 1'b0;
        check("pulse_end", int'({bus.res_valid, bus.busy, bus.core_rst}), 1);
        check("hold", int'({bus.res_cover, bus.res_timeout}), int'({6'(exp_cov), w > 0 ? 1'b0 : 1'b1}));
        if (disturb) begin
            repeat (4) @(posedge clk);
            #1;
            check("no_rerun", int'({bus.res_valid, bus.busy}), 0);
        end
    endtask
    initial begin
        bus.wr_en = 1'b0;
        bus.wr_addr = '0;
        bus.wr_x = '0;
        bus.wr_y = '0;
        bus.start = 1'b0;
        bus.done = 1'b0;
        noise_core();
        #1 rst_n = 1'b0;
        #2;
        check("reset", int'({bus.core_rst, bus.busy, bus.res_valid, bus.res_timeout, bus.x, bus.y}), int'({4'b1000, 8'd0}));
        check("reset_res", int'({bus.res_c1x, bus.res_c1y, bus.res_c2x, bus.res_c2y, bus.res_cover}), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        // Stream order pattern, with a write riding on the START cycle
        for (int i = 0; i < NPTS; i++) wr(i, 4'(i % 16), 4'(15 - i % 16));
        for (int a = NPTS; a < 64; a++) wr(a, 4'd7, 4'd7);
        run_job(3, 4'd2, 4'd13, 4'd10, 4'd5, 1'b0, 1'b1, 0, 4'd5, 4'd9);
        // All points on C1
        for (int i = 0; i < NPTS; i++) wr(i, 4'd8, 4'd8);
        run_job(1, 4'd8, 4'd8, 4'd0, 4'd0, 1'b0, 1'b0, 0, 4'd0, 4'd0);
        check("cover_all", int'(bus.res_cover), NPTS);
        // Radius boundary: 16 is covered, 18 is not
        wr(0, 4'd4, 4'd0);
        wr(1, 4'd0, 4'd4);
        wr(2, 4'd3, 4'd3);
        for (int i = 3; i < NPTS; i++) wr(i, 4'd15, 4'd15);
        run_job(5, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 0, 4'd0, 4'd0);
        check("cover_edge", int'(bus.res_cover), 2);
        // Core never answers
        for (int i = 0; i < NPTS; i++) wr(i, 4'($urandom), 4'($urandom));
        run_job(0, 4'd1, 4'd2, 4'd3, 4'd4, 1'b0, 1'b0, 0, 4'd0, 4'd0);
        // Writes, START and early DONE while busy are all ignored
        run_job(6, 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 1'b1, 1'b0, 0, 4'd0, 4'd0);
        // Reset during stream cycle 20
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (20) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("rst_mid", int'({bus.core_rst, bus.busy, bus.x, bus.res_valid}), int'({2'b10, 4'd0, 1'b0}));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_job(2, 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 1'b0, 1'b0, 0, 4'd0, 4'd0);
        // Random jobs with points clustered so coverage varies
        for (int j = 0; j < 6; j++) begin
            logic [3:0] cx, cy;
            cx = 4'($urandom);
            cy = 4'($urandom);
            for (int i = 0; i < NPTS; i++)
                wr(i, 4'(int'(cx) + $urandom_range(0, 6) - 3), 4'(int'(cy) + $urandom_range(0, 6) - 3));
            run_job($urandom_range(1, 30), cx, cy, 4'($urandom), 4'($urandom), 1'b0,
                    1'($urandom), $urandom_range(0, NPTS - 1), 4'($urandom), 4'($urandom));
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/laser_point_feeder.md
Name: laser_point_feeder

Overview:
- Host-side driver for the two-circle laser core.
- Holds a 40-entry point memory loaded by the host. On START it releases the core's reset and streams one point per cycle on the core's X/Y inputs.
- Waits for the core's DONE, then captures C1X/C1Y/C2X/C2Y.
- Independently scores the returned circle pair by counting the stored points covered, then reports the result to the host.

Parameters:
- NPTS, 40, number of points streamed per job; also the memory depth.
- TIMEOUT, 1023, maximum WAIT_DONE cycles before the job is aborted.
- RADIUS_SQ, 16, squared circle radius used in scoring.

Ports:
- CLK  in  1  clock; all flops on the rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- WR_EN  in  1  host point-memory write strobe.
- WR_ADDR  in  6  write index, 0..NPTS-1.
- WR_X  in  4  point X coordinate.
- WR_Y  in  4  point Y coordinate.
- START  in  1  begin a job; sampled only in IDLE.
- BUSY  out  1  high from the cycle after START was accepted through REPORT.
- CORE_RST  out  1  active-high reset to the core.
- X  out  4  streamed point X coordinate, registered.
- Y  out  4  streamed point Y coordinate, registered.
- C1X, C1Y, C2X, C2Y  in  4 each  circle centres from the core.
- DONE  in  1  core result-valid flag.
- RES_VALID  out  1  one-cycle pulse; result fields are valid.
- RES_C1X, RES_C1Y, RES_C2X, RES_C2Y  out  4 each  captured centres.
- RES_COVER  out  6  number of points covered by either circle.
- RES_TIMEOUT  out  1  job aborted because DONE never arrived.

Behaviour:
- Reset values:
  - CORE_RST=1.
  - X=Y=0.
  - BUSY=0, RES_VALID=0, RES_TIMEOUT=0.
  - All RES_* fields = 0.
  - State = IDLE, all counters = 0.
  - Point memory is not reset; it keeps its contents.
- Reset mid-job: abort immediately to the reset values above; the core is re-held in reset.
- Memory writes:
  - Accepted only in IDLE (BUSY=0).
  - WR_ADDR >= NPTS is ignored.
  - A write in the same cycle as an accepted START is committed, and is visible to the stream.
- States: IDLE, STREAM, WAIT_DONE, SCORE, REPORT.
- IDLE:
  - CORE_RST=1, X=Y=0.
  - START=1 at edge t: go to STREAM and clear the index counter.
- STREAM:
  - From edge t+1: CORE_RST=0 and X/Y = point[0].
  - point[k] is presented during cycle t+1+k, for k = 0..NPTS-1, with no gaps.
  - After point[NPTS-1]: go to WAIT_DONE with X=Y=0 and CORE_RST held 0.
- WAIT_DONE:
  - Timeout counter increments every cycle.
  - DONE=1 sampled: latch C1X..C2Y into RES_C*, go to SCORE.
  - Counter reaches TIMEOUT first: RES_TIMEOUT=1, RES_C*=0, RES_COVER=0, go straight to REPORT.
  - DONE arriving during STREAM is ignored.
- SCORE:
  - Handles one point per cycle, NPTS cycles total; CORE_RST returns to 1.
  - dx and dy are signed 5-bit differences (point minus centre); each square is 8-bit unsigned; the sum is 9-bit.
  - A point is covered if dx²+dy² <= RADIUS_SQ for C1 or for C2.
  - RES_COVER increments at most once per point; maximum value is 40.
- REPORT:
  - RES_VALID=1 for exactly one cycle, then IDLE.
  - BUSY drops in the following IDLE cycle.
  - RES_* fields hold until the next accepted START clears them.
- START while BUSY: ignored, not queued.
- Total latency, START to RES_VALID: 1 + NPTS + (DONE wait) + NPTS + 1 cycles.

Test Plan:
- Stream order:
  - Stimulus: load point[i] = (i mod 16, 15 - i mod 16) for all 40 entries, then pulse START.
  - Required: CORE_RST falls one cycle after START; X/Y match point[i] on 40 consecutive cycles; then X=Y=0.
- Scoring:
  - Stimulus: all 40 points = (8,8); core model returns DONE with C1=(8,8), C2=(0,0).
  - Required: RES_C1=(8,8), RES_C2=(0,0), RES_COVER=40, RES_TIMEOUT=0, RES_VALID pulses once.
- Radius boundary:
  - Stimulus: points (4,0), (0,4) and (3,3) with C1=C2=(0,0); remaining 37 points = (15,15).
  - Required: (4,0) and (0,4) give distance² 16 (covered); (3,3) gives 18 (not covered); RES_COVER=2.
- Timeout:
  - Stimulus: core model never asserts DONE.
  - Required: RES_VALID with RES_TIMEOUT=1, RES_COVER=0, RES_C*=0, after 1+40+1023+1 cycles.
- Ignored inputs:
  - Stimulus: WR_EN and START pulsed while BUSY=1.
  - Required: memory unchanged, the job is not restarted, and no extra RES_VALID is produced.
- Reset mid-job:
  - Stimulus: RST_N low during STREAM cycle 20, then START again.
  - Required: immediately CORE_RST=1, BUSY=0, X=0. The rerun streams the original memory contents.
